// File: rtl/srl_tap_delay_if.sv
// ---------------------------------------------------------------------------
// srl_tap_delay_if
//
// Purpose: bundles the data-path signals of the tapped shift-register delay
// line so the delay line and whatever drives it share one declaration.
//
// Signals (clk and rst_n stay outside the interface as plain ports):
//   ce     - shift enable, all lanes shift together
//   flush  - synchronous clear of the fill count (stored data is kept)
//   din    - LANES*WIDTH input, lane L at [L*WIDTH +: WIDTH]
//   tap    - stage index to read, 0 = newest sample
//   dout   - stage[tap] of every lane, same lane packing as din
//   valid  - dout holds a sample written since the last flush/reset
//   fill   - number of valid stages, 0..DEPTH
//   full   - fill == DEPTH
//
// Modports: master drives ce/flush/din/tap, slave (the delay line) drives
// dout/valid/fill/full.
// ---------------------------------------------------------------------------
interface srl_tap_delay_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int LANES = 4
) ();
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic                   ce;
   logic                   flush;
   logic [LANES*WIDTH-1:0] din;
   logic [AW-1:0]          tap;
   logic [LANES*WIDTH-1:0] dout;
   logic                   valid;
   logic [CW-1:0]          fill;
   logic                   full;

   modport master (
      output ce, flush, din, tap,
      input  dout, valid, fill, full
   );

   modport slave (
      input  ce, flush, din, tap,
      output dout, valid, fill, full
   );
endinterface

// File: rtl/srl_tap_delay.sv
// ---------------------------------------------------------------------------
// srl_tap_delay
//
// Purpose: multi-lane shift-register delay line with a runtime-selectable
// read tap. LANES independent WIDTH-bit lanes share one shift enable and
// one read address, so the structure maps onto dynamic-address SRLs. A fill
// counter tracks how many stages hold samples written since the last
// flush/reset, which drives the valid flag for the selected tap.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset (clears storage, fill, outputs)
//   bus    - srl_tap_delay_if.slave: ce, flush, din, tap in;
//            dout, valid, fill, full out
//
// Configuration macro:
//   SRL_TAP_OUTREG_EN - when defined, dout/valid are registered (one extra
//                       cycle of latency, register updates every cycle
//                       regardless of ce). When undefined, the read path is
//                       purely combinational from storage, fill and tap.
// ---------------------------------------------------------------------------
module srl_tap_delay #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int LANES = 4
) (
   input logic          clk,
   input logic          rst_n,
   srl_tap_delay_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0]       stage_q [LANES][DEPTH];
   logic [CW-1:0]          fill_q;
   logic [CW-1:0]          fill_d;
   logic [CW-1:0]          tapExt;
   logic                   tapInRange;
   logic [LANES*WIDTH-1:0] readData_d;
   logic                   readValid_d;

   // Storage: every lane shifts by one stage on ce; the oldest sample falls
   // off the end. Flush deliberately leaves the data alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < DEPTH; k++) begin
               stage_q[l][k] <= '0;
            end
         end
      end else if (bus.ce) begin
         for (int l = 0; l < LANES; l++) begin
            stage_q[l][0] <= bus.din[l*WIDTH +: WIDTH];
            for (int k = 1; k < DEPTH; k++) begin
               stage_q[l][k] <= stage_q[l][k-1];
            end
         end
      end
   end

   // Fill counter next state: flush restarts the count (at 1 if this same
   // edge also shifts a sample in), otherwise count shifts up to DEPTH.
   always_comb begin
      fill_d = fill_q;
      if (bus.flush) begin
         fill_d = bus.ce ? CW'(1) : '0;
      end else if (bus.ce && (fill_q != DEPTH_C)) begin
         fill_d = fill_q + CW'(1);
      end
   end

   // Fill counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end

   // Read mux: a tap beyond the last stage (possible when DEPTH is not a
   // power of two) reads as zero and invalid instead of indexing past the
   // array. Since fill never exceeds DEPTH, tap < fill alone implies range.
   always_comb begin
      tapExt      = CW'(bus.tap);
      tapInRange  = (tapExt < DEPTH_C);
      readData_d  = '0;
      readValid_d = 1'b0;
      if (tapInRange) begin
         for (int l = 0; l < LANES; l++) begin
            readData_d[l*WIDTH +: WIDTH] = stage_q[l][bus.tap];
         end
         readValid_d = (tapExt < fill_q);
      end
   end

`ifdef SRL_TAP_OUTREG_EN
   logic [LANES*WIDTH-1:0] dout_q;
   logic                   valid_q;

   // Registered read port: captures the pre-edge combinational read every
   // cycle, independent of ce, so tap changes show up one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         dout_q  <= readData_d;
         valid_q <= readValid_d;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.valid = valid_q;
`else
   assign bus.dout  = readData_d;
   assign bus.valid = readValid_d;
`endif

   assign bus.fill = fill_q;
   assign bus.full = (fill_q == DEPTH_C);
endmodule

// File: tb/tb_srl_tap_delay.sv
// ---------------------------------------------------------------------------
// tb_srl_tap_delay
//
// Purpose: directed self-checking bench for srl_tap_delay. Two instances:
// dutA (DEPTH=16) for reset/delay/saturation/hold/flush/tap-change and dutB
// (DEPTH=12) for out-of-range taps. Expected values are computed by hand
// from the sample numbering: the sample shifted in on ce edge j (counting
// from 1 after reset) has lane L value 8'h10*L + j.
// With SRL_TAP_OUTREG_EN defined the expected read is the one from one
// edge earlier (LAT=1).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_srl_tap_delay;
`ifdef SRL_TAP_OUTREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif
   localparam int W  = 8;
   localparam int NL = 4;
   localparam int BW = NL * W;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   srl_tap_delay_if #(.WIDTH(W), .DEPTH(16), .LANES(NL)) aIf ();
   srl_tap_delay_if #(.WIDTH(W), .DEPTH(12), .LANES(NL)) bIf ();

   srl_tap_delay #(.WIDTH(W), .DEPTH(16), .LANES(NL)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (aIf.slave)
   );

   srl_tap_delay #(.WIDTH(W), .DEPTH(12), .LANES(NL)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lane values of the sample written on edge j.
   function automatic logic [BW-1:0] laneVals(input int j);
      logic [BW-1:0] v;
      for (int l = 0; l < NL; l++) begin
         v[l*W +: W] = 8'(16 * l + j);
      end
      return v;
   endfunction

   // Stage t after k edges holds the sample from edge k-t (zero if none yet).
   function automatic logic [BW-1:0] expLanes(input int t, input int k, input int depth);
      if (t < depth && (k - t) >= 1) return laneVals(k - t);
      return '0;
   endfunction

   function automatic logic expValid(input int t, input int k, input int depth);
      int f;
      f = (k < depth) ? k : depth;
      if (f < 0) f = 0;
      return (t < f);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      aIf.ce = 1'b0; aIf.flush = 1'b0; aIf.din = '0; aIf.tap = '0;
      bIf.ce = 1'b0; bIf.flush = 1'b0; bIf.din = '0; bIf.tap = '0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      aIf.tap = 4'd0;
      for (int k = 1; k <= 3; k++) begin
         aIf.din = laneVals(k + 40);
         aIf.ce  = 1'b1;
         tick();
      end
      total++;
      if (aIf.fill !== 5'd3) begin
         bad++;
         $display("FAIL reset_prefill: fill=%0d want 3", aIf.fill);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (aIf.dout !== '0 || aIf.fill !== '0 || aIf.full !== 1'b0 || aIf.valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: dout=%h fill=%0d full=%b valid=%b want all 0",
                  aIf.dout, aIf.fill, aIf.full, aIf.valid);
      end
      for (int c = 0; c < 3; c++) begin
         aIf.din = (c % 2 == 0) ? 32'hFFFF_FFFF : 32'h5A5A_5A5A;
         aIf.ce  = 1'b1;
         tick();
         total++;
         if (aIf.dout !== '0 || aIf.fill !== '0 || aIf.full !== 1'b0 || aIf.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: dout=%h fill=%0d full=%b valid=%b want all 0",
                     c, aIf.dout, aIf.fill, aIf.full, aIf.valid);
         end
      end
      rst_n   = 1'b1;
      aIf.din = laneVals(1);
      tick();
      aIf.ce = 1'b0;
      total++;
      if (aIf.fill !== 5'd1) begin
         bad++;
         $display("FAIL reset_release: fill=%0d want 1", aIf.fill);
      end
   endtask

   task automatic test_delay();
      doReset();
      aIf.tap = 4'd5;
      for (int k = 1; k <= 12; k++) begin
         aIf.din = laneVals(k);
         aIf.ce  = 1'b1;
         tick();
         total++;
         if (aIf.fill !== 5'(k)) begin
            bad++;
            $display("FAIL delay_fill[%0d]: fill=%0d want %0d", k, aIf.fill, k);
         end
         total++;
         if (aIf.valid !== expValid(5, k - LAT, 16) || aIf.dout !== expLanes(5, k - LAT, 16)) begin
            bad++;
            $display("FAIL delay_read[%0d]: dout=%h valid=%b want %h %b", k, aIf.dout, aIf.valid,
                     expLanes(5, k - LAT, 16), expValid(5, k - LAT, 16));
         end
      end
      aIf.ce = 1'b0;
   endtask

   task automatic test_saturation();
      doReset();
      aIf.tap = 4'd15;
      for (int k = 1; k <= 20; k++) begin
         aIf.din = laneVals(k);
         aIf.ce  = 1'b1;
         tick();
         total++;
         if (aIf.fill !== 5'((k < 16) ? k : 16) || aIf.full !== (k >= 16)) begin
            bad++;
            $display("FAIL sat_fill[%0d]: fill=%0d full=%b want %0d %b", k, aIf.fill, aIf.full,
                     (k < 16) ? k : 16, (k >= 16));
         end
         total++;
         if (aIf.valid !== expValid(15, k - LAT, 16) || aIf.dout !== expLanes(15, k - LAT, 16)) begin
            bad++;
            $display("FAIL sat_read[%0d]: dout=%h valid=%b want %h %b", k, aIf.dout, aIf.valid,
                     expLanes(15, k - LAT, 16), expValid(15, k - LAT, 16));
         end
      end
      aIf.ce = 1'b0;
   endtask

   task automatic test_hold_flush();
      // continues from the 20-edge state left by test_saturation, tap=15
      for (int c = 0; c < 4; c++) begin
         tick();
         total++;
         if (aIf.fill !== 5'd16 || aIf.valid !== 1'b1 || aIf.dout !== laneVals(5)) begin
            bad++;
            $display("FAIL hold[%0d]: fill=%0d valid=%b dout=%h want 16 1 %h", c, aIf.fill,
                     aIf.valid, aIf.dout, laneVals(5));
         end
      end
      aIf.din   = laneVals(21);
      aIf.flush = 1'b1;
      aIf.ce    = 1'b1;
      tick();
      aIf.flush = 1'b0;
      aIf.ce    = 1'b0;
      total++;
      if (aIf.fill !== 5'd1 || aIf.full !== 1'b0) begin
         bad++;
         $display("FAIL flush_ce_fill: fill=%0d full=%b want 1 0", aIf.fill, aIf.full);
      end
      aIf.tap = 4'd0;
      if (LAT != 0) tick();
      #1;
      total++;
      if (aIf.valid !== 1'b1 || aIf.dout !== laneVals(21)) begin
         bad++;
         $display("FAIL flush_tap0: valid=%b dout=%h want 1 %h", aIf.valid, aIf.dout, laneVals(21));
      end
      aIf.tap = 4'd1;
      if (LAT != 0) tick();
      #1;
      total++;
      if (aIf.valid !== 1'b0 || aIf.dout !== laneVals(20)) begin
         bad++;
         $display("FAIL flush_tap1: valid=%b dout=%h want 0 %h", aIf.valid, aIf.dout, laneVals(20));
      end
      aIf.flush = 1'b1;
      tick();
      aIf.flush = 1'b0;
      total++;
      if (aIf.fill !== 5'd0) begin
         bad++;
         $display("FAIL flush_noce_fill: fill=%0d want 0", aIf.fill);
      end
      aIf.tap = 4'd0;
      if (LAT != 0) tick();
      #1;
      total++;
      if (aIf.valid !== 1'b0 || aIf.dout !== laneVals(21)) begin
         bad++;
         $display("FAIL flush_noce_read: valid=%b dout=%h want 0 %h", aIf.valid, aIf.dout, laneVals(21));
      end
   endtask

   task automatic test_tap_change();
      doReset();
      for (int k = 1; k <= 10; k++) begin
         aIf.din = laneVals(k);
         aIf.ce  = 1'b1;
         tick();
      end
      aIf.ce  = 1'b0;
      aIf.tap = 4'd3;
      tick();
      total++;
      if (aIf.valid !== 1'b1 || aIf.dout !== laneVals(7)) begin
         bad++;
         $display("FAIL tap3: valid=%b dout=%h want 1 %h", aIf.valid, aIf.dout, laneVals(7));
      end
      aIf.tap = 4'd7;
      #1;
      total++;
      if (aIf.dout !== ((LAT != 0) ? laneVals(7) : laneVals(3))) begin
         bad++;
         $display("FAIL tap7_same_cycle: dout=%h want %h", aIf.dout,
                  (LAT != 0) ? laneVals(7) : laneVals(3));
      end
      tick();
      total++;
      if (aIf.valid !== 1'b1 || aIf.dout !== laneVals(3)) begin
         bad++;
         $display("FAIL tap7_next_cycle: valid=%b dout=%h want 1 %h", aIf.valid, aIf.dout, laneVals(3));
      end
   endtask

   task automatic test_out_of_range();
      doReset();
      bIf.tap = 4'd11;
      for (int k = 1; k <= 12; k++) begin
         bIf.din = laneVals(k);
         bIf.ce  = 1'b1;
         tick();
         if (k == 11) begin
            total++;
            if (bIf.valid !== 1'b0 || bIf.fill !== 4'd11) begin
               bad++;
               $display("FAIL oor_tap11_early: valid=%b fill=%0d want 0 11", bIf.valid, bIf.fill);
            end
         end
      end
      bIf.ce = 1'b0;
      total++;
      if (bIf.fill !== 4'd12 || bIf.full !== 1'b1) begin
         bad++;
         $display("FAIL oor_full: fill=%0d full=%b want 12 1", bIf.fill, bIf.full);
      end
      bIf.tap = 4'd13;
      if (LAT != 0) tick();
      #1;
      total++;
      if (bIf.valid !== 1'b0 || bIf.dout !== '0) begin
         bad++;
         $display("FAIL oor_tap13: valid=%b dout=%h want 0 0", bIf.valid, bIf.dout);
      end
      bIf.tap = 4'd12;
      if (LAT != 0) tick();
      #1;
      total++;
      if (bIf.valid !== 1'b0 || bIf.dout !== '0) begin
         bad++;
         $display("FAIL oor_tap12: valid=%b dout=%h want 0 0", bIf.valid, bIf.dout);
      end
      bIf.tap = 4'd11;
      if (LAT != 0) tick();
      #1;
      total++;
      if (bIf.valid !== 1'b1 || bIf.dout !== laneVals(1)) begin
         bad++;
         $display("FAIL oor_tap11: valid=%b dout=%h want 1 %h", bIf.valid, bIf.dout, laneVals(1));
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      aIf.ce = 1'b0; aIf.flush = 1'b0; aIf.din = '0; aIf.tap = '0;
      bIf.ce = 1'b0; bIf.flush = 1'b0; bIf.din = '0; bIf.tap = '0;
      tick();
      tick();
      rst_n = 1'b1;
      test_reset();
      test_delay();
      test_saturation();
      test_hold_flush();
      test_tap_change();
      test_out_of_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
